// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encoding, widths, op indices and opcode decode for alu_sequencer
package alu_seq_pkg;
  localparam int OP_W = 3;
  localparam int OPCODE_W = 16;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, RESP} state_t;
  localparam logic [OP_W-1:0] OP_SHR2_FILL = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB_INC3 = 3'd1;
  localparam logic [OP_W-1:0] OP_MAX = 3'd2;
  localparam logic [OP_W-1:0] OP_NIBSWAP = 3'd3;
  localparam logic [OP_W-1:0] OP_INC = 3'd4;
  localparam logic [OP_W-1:0] OP_AND = 3'd5;
  localparam logic [OP_W-1:0] OP_INV_HI = 3'd6;
  localparam logic [OP_W-1:0] OP_ROL3 = 3'd7;
  function automatic logic [OPCODE_W-1:0] op_to_onehot(input logic [OP_W-1:0] op);
    return {{(OPCODE_W-1){1'b0}}, 1'b1} << op;
  endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: handshake-driven ALU opcode/operand sequencer; ALU_SEQ_STATS_EN adds op_count/stall_count
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [7:0]          cmd_a,
  input  logic [7:0]          cmd_b,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [OPCODE_W-1:0] alu_opcode,
  input  logic [3:0]          alu_r1,
  input  logic [3:0]          alu_r2,
  input  logic                alu_neg,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_result,
  output logic                rsp_neg,
  output logic [OP_W-1:0]     rsp_op,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]         op_count,
  output logic [15:0]         stall_count,
`endif
  output logic                busy
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end
  state_t state, state_n;
  logic [3:0] cnt;
  logic [OP_W-1:0] op;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid ? LOAD : IDLE;
      LOAD:    state_n = SETTLE;
      SETTLE:  state_n = cnt == 4'd0 ? CAPTURE : SETTLE;
      CAPTURE: state_n = RESP;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_neg <= 1'b0;
      rsp_op <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        alu_a <= cmd_a;
        alu_b <= cmd_b;
        op <= cmd_op;
      end
      if (state == LOAD) begin
        alu_opcode <= op_to_onehot(op);
        cnt <= 4'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == CAPTURE) begin
        rsp_result <= {alu_r2, alu_r1};
        rsp_neg <= alu_neg;
        rsp_op <= op;
        alu_opcode <= '0;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
      stall_count <= '0;
    end else begin
      if (state == RESP && rsp_ready) op_count <= op_count + 16'd1;
      if (state == RESP && !rsp_ready && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a small combinational ALU model
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [7:0] alu_a, alu_b;
  logic [15:0] alu_opcode;
  logic [3:0] alu_r1, alu_r2;
  logic alu_neg;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic rsp_neg;
  logic [2:0] rsp_op;
  logic busy;
  logic [7:0] mres;
  int tests = 0, fails = 0;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count, stall_count;
`endif
  alu_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_neg(alu_neg), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_op(rsp_op),
`ifdef ALU_SEQ_STATS_EN
    .op_count(op_count), .stall_count(stall_count),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb begin
    mres = 8'h00;
    alu_neg = 1'b0;
    if (alu_opcode[5]) mres = alu_a & alu_b;
    else if (alu_opcode[4]) mres = alu_a + 8'd1;
    else if (alu_opcode[1]) begin
      mres = alu_a - alu_b + 8'd3;
      alu_neg = alu_a < alu_b;
    end
  end
  assign {alu_r2, alu_r1} = mres;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    tests++;
    if (alu_opcode !== 16'h0 || alu_a !== 8'h0 || alu_b !== 8'h0) begin
      fails++;
      $display("FAIL reset_alu: opcode=%h a=%h b=%h required 0", alu_opcode, alu_a, alu_b);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_result !== 8'h0 || rsp_neg !== 1'b0 || rsp_op !== 3'd0) begin
      fails++;
      $display("FAIL reset_rsp: v=%b res=%h neg=%b op=%0d required 0", rsp_valid, rsp_result, rsp_neg, rsp_op);
    end
`ifdef ALU_SEQ_STATS_EN
    tests++;
    if (op_count !== 16'h0 || stall_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_stats: op_count=%h stall_count=%h required 0", op_count, stall_count);
    end
`endif
  endtask

  task automatic test_single();
    logic [15:0] exp_opc;
    rsp_ready = 1'b0;
    issue(OP_AND, 8'hF0, 8'h3C);
    tests++;
    if (alu_a !== 8'hF0 || alu_b !== 8'h3C || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_load: a=%h b=%h busy=%b ready=%b required f0 3c 1 0", alu_a, alu_b, busy, cmd_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      exp_opc = (k >= 2 && k <= 4) ? 16'h0020 : 16'h0000;
      tests++;
      if (alu_opcode !== exp_opc || rsp_valid !== (k >= 5)) begin
        fails++;
        $display("FAIL single_timing_T+%0d: opcode=%h rsp_valid=%b required %h %b", k, alu_opcode, rsp_valid, exp_opc, k >= 5);
      end
      if (k == 5) begin
        tests++;
        if (rsp_result !== 8'h30 || rsp_neg !== 1'b0 || rsp_op !== 3'd5) begin
          fails++;
          $display("FAIL single_rsp: res=%h neg=%b op=%0d required 30 0 5", rsp_result, rsp_neg, rsp_op);
        end
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, zrun = 0, gap = -1, rsps = 0;
    logic [7:0] res [2];
    res[0] = 8'hxx;
    res[1] = 8'hxx;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = OP_INC;
    cmd_a = 8'h0F;
    cmd_b = 8'h00;
    for (int i = 0; i < 40 && rsps < 2; i++) begin
      if (alu_opcode != 16'h0) begin
        if (zrun > 0) begin
          pulses++;
          if (pulses == 2) gap = zrun;
        end
        zrun = 0;
        tests++;
        if (alu_opcode !== 16'h0010) begin
          fails++;
          $display("FAIL b2b_opcode: opcode=%h required 0010", alu_opcode);
        end
      end else zrun++;
      if (rsp_valid) begin
        res[rsps] = rsp_result;
        rsps++;
        if (rsps == 2) cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tests++;
    if (rsps != 2 || res[0] !== 8'h10 || res[1] !== 8'h10) begin
      fails++;
      $display("FAIL b2b_results: count=%0d r0=%h r1=%h required 2 10 10", rsps, res[0], res[1]);
    end
    tests++;
    if (pulses != 2 || gap < 3) begin
      fails++;
      $display("FAIL b2b_gap: pulses=%0d gap=%0d required 2 >=3", pulses, gap);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r;
    logic n;
    logic [2:0] o;
    bit bad = 0;
    rsp_ready = 1'b0;
    issue(OP_AND, 8'hF0, 8'h3C);
    wait_rsp("bp");
    r = rsp_result;
    n = rsp_neg;
    o = rsp_op;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 3);
      cmd_op = OP_INC;
      cmd_a = 8'h0F;
      cmd_b = 8'h01;
      if (rsp_valid !== 1'b1 || rsp_result !== r || rsp_neg !== n || rsp_op !== o || cmd_ready !== 1'b0) bad = 1;
      tick();
    end
    cmd_valid = 1'b0;
    tests++;
    if (bad || r !== 8'h30 || o !== 3'd5) begin
      fails++;
      $display("FAIL bp_hold: res=%h op=%0d unstable=%0d required 30 5 0", r, o, bad);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || alu_a !== 8'hF0 || alu_b !== 8'h3C) begin
      fails++;
      $display("FAIL bp_no_queue: busy=%b a=%h b=%h required 0 f0 3c", busy, alu_a, alu_b);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    rsp_ready = 1'b1;
    issue(OP_AND, 8'hAA, 8'h0F);
    tick();
    tick();
    tests++;
    if (alu_opcode !== 16'h0020 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_settle: opcode=%h busy=%b required 0020 1", alu_opcode, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || alu_opcode !== 16'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_abort: busy=%b opcode=%h rsp_valid=%b ready=%b required 0 0 0 1", busy, alu_opcode, rsp_valid, cmd_ready);
    end
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid || alu_opcode != 16'h0) seen = 1;
      tick();
    end
    rsp_ready = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rmid_no_rsp: activity=%0d required 0", seen);
    end
  endtask

  task automatic test_neg_stats();
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_STATS_EN
    @(negedge clk);
    dut.op_count = 16'hFFFF;
    #1;
`endif
    issue(OP_SUB_INC3, 8'h05, 8'h07);
    wait_rsp("neg");
    tests++;
    if (rsp_result !== 8'h01 || rsp_neg !== 1'b1 || rsp_op !== 3'd1) begin
      fails++;
      $display("FAIL neg_rsp: res=%h neg=%b op=%0d required 01 1 1", rsp_result, rsp_neg, rsp_op);
    end
    repeat (3) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL neg_done: rsp_valid=%b required 0", rsp_valid);
    end
`ifdef ALU_SEQ_STATS_EN
    tests++;
    if (op_count !== 16'h0000 || stall_count !== 16'd3) begin
      fails++;
      $display("FAIL stats: op_count=%h stall_count=%0d required 0000 3", op_count, stall_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_neg_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
